load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: the number of cycles waited for dm_ack before abort (used only under LSU_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1: request strobe, sampled only in IDLE.
REQ-005 SHALL have port is_store, input, 1: 1 = store, 0 = load; captured with start.
REQ-006 SHALL have port mem_code, input, 3: access size from ALU control. 001 = byte signed, 010 = half signed, 011 = word, 101 = byte unsigned; all other values illegal.
REQ-007 SHALL have port addr, input, 32: byte address (ALU result).
REQ-008 SHALL have port wdata, input, 32: store data (rs2), right-justified.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port fault, output, 1: valid with done; 1 = misaligned, illegal code or timeout.
REQ-012 SHALL have port rdata, output, 32: extended load result; held until the next done.
REQ-013 SHALL have port dm_req, output, 1: memory request, held until acknowledged.
REQ-014 SHALL have port dm_we, output, 1: memory write enable.
REQ-015 SHALL have port dm_addr, output, 32: word-aligned address (addr with [1:0] forced to 0).
REQ-016 SHALL have port dm_be, output, 4: byte enables.
REQ-017 SHALL have port dm_wdata, output, 32: lane-steered store data.
REQ-018 SHALL have port dm_ack, input, 1: memory acknowledge. dm_rdata is valid in the same cycle.
REQ-019 SHALL have port dm_rdata, input, 32: memory read word.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, RESP. IDLE goes to REQ when start is high and the access is legal; REQ goes to RESP when dm_ack is high; RESP returns to IDLE.
REQ-021 SHALL, on start in IDLE, register is_store, mem_code, addr and wdata; inputs after that edge SHALL NOT affect the access.
REQ-022 SHALL treat these as illegal: half access with addr[0] = 1, word access with addr[1:0] != 0, or an undefined mem_code. An illegal start SHALL issue no dm_req and SHALL pulse done = 1, fault = 1 exactly one cycle later, with rdata unchanged.
REQ-023 SHALL drive dm_req high from the cycle after start until and including the dm_ack cycle; dm_addr, dm_we, dm_be and dm_wdata SHALL stay stable while dm_req is high.
REQ-024 SHALL generate dm_be as follows: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << addr[1:0]; word = 4'b1111.
REQ-025 SHALL drive dm_wdata as the byte replicated ×4 (byte), the half replicated ×2 (half), or wdata (word).
REQ-026 SHALL, on a load, select the addressed lane of dm_rdata at the dm_ack edge, then sign-extend (codes 001 and 010) or zero-extend (code 101) it into rdata.
REQ-027 SHALL pulse done in RESP, giving a legal access latency of 2 + N cycles from start, where N is the number of wait cycles before dm_ack; with dm_ack in the first REQ cycle, done occurs 2 cycles after start.
REQ-028 SHALL ignore start while busy, and ignore dm_ack when dm_req is low.
REQ-029 SHALL leave rdata unchanged on a store or on a fault.

Reset
REQ-030 SHALL, while rst_n is low, immediately force state to IDLE and busy, done, fault, dm_req, dm_we, dm_be, dm_addr, dm_wdata and rdata to 0.
REQ-031 SHALL abandon any in-flight access on reset mid-operation and issue no done for it.

Configuration
REQ-032 SHALL, with LSU_TIMEOUT_EN defined, count cycles in REQ; after TIMEOUT_CYCLES cycles without dm_ack it SHALL drop dm_req, enter RESP, and pulse done with fault = 1. A late dm_ack SHALL be ignored.
REQ-033 SHALL, without LSU_TIMEOUT_EN, contain no timeout counter and wait in REQ indefinitely.

Structure
REQ-034 SHALL place the mem_code constants, the FSM state typedef and the byte-enable patterns in package lsu_pkg, shared with ALU control.
REQ-035 SHALL put lane steering and extension in one combinational sub-module, lsu_align.

Verification
REQ-036 SHALL cover a word store: start, is_store = 1, code 011, addr = 0x104, wdata = 0xDEADBEEF, ack at the first REQ cycle. Expected: dm_addr = 0x104, dm_be = 1111, dm_wdata = 0xDEADBEEF, done at start + 2, fault = 0.
REQ-037 SHALL cover a signed byte load: code 001, addr = 0x203, dm_rdata = 0x80FFFFFF, ack after 3 waits. Expected: dm_be = 1000, rdata = 0xFFFFFF80, done at start + 5.
REQ-038 SHALL cover an unsigned byte and a half load: code 101, addr = 0x203, dm_rdata = 0x80000000 gives rdata = 0x00000080; code 010, addr = 0x202, dm_rdata = 0x8001_0000 gives rdata = 0xFFFF8001.
REQ-039 SHALL cover a misaligned access: code 011, addr = 0x102. Expected: dm_req never high, done = 1 and fault = 1 at start + 1, rdata unchanged.
REQ-040 SHALL cover timeout: with LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack. Expected: dm_req high for 4 cycles, then done = 1, fault = 1; a late ack causes no second done.
REQ-041 SHALL cover reset and busy cases: rst_n low during REQ drops dm_req and busy at once, with no done after release; start while busy is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load/store definitions: mem_code values, FSM states, byte-enable
// patterns and the access legality check. Also used by ALU control.
package lsu_pkg;

  // Access size codes produced by ALU control
  localparam logic [2:0] MC_BYTE_S = 3'b001;
  localparam logic [2:0] MC_HALF_S = 3'b010;
  localparam logic [2:0] MC_WORD   = 3'b011;
  localparam logic [2:0] MC_BYTE_U = 3'b101;

  // Byte-enable patterns for lane 0; shifted by the byte offset
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // A request is legal when the code is defined and the address is
  // naturally aligned for the access size.
  function automatic logic access_legal(input logic [2:0] code, input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    case (code)
      MC_BYTE_S, MC_BYTE_U: ok = 1'b1;
      MC_HALF_S:            ok = (lo[0] == 1'b0);
      MC_WORD:              ok = (lo == 2'b00);
      default:              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for stores and lane selection plus extension for loads.
// Purely combinational. The store side and the load side take separate
// inputs because the store lanes are computed from the live request while
// the load lane comes from the captured request.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_code,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_steered,
  input  logic [2:0]  ld_code,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_result
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Store side: byte enables and replicated write data
  always_comb begin
    st_be            = 4'b0000;
    st_wdata_steered = 32'h0000_0000;
    case (st_code)
      MC_BYTE_S, MC_BYTE_U: begin
        st_be            = BE_BYTE << st_lane;
        st_wdata_steered = {4{st_wdata[7:0]}};
      end
      MC_HALF_S: begin
        st_be            = BE_HALF << st_lane;
        st_wdata_steered = {2{st_wdata[15:0]}};
      end
      MC_WORD: begin
        st_be            = BE_WORD;
        st_wdata_steered = st_wdata;
      end
      default: begin
        st_be            = 4'b0000;
        st_wdata_steered = 32'h0000_0000;
      end
    endcase
  end

  // Load side: pick the addressed byte/half, then sign- or zero-extend
  always_comb begin
    ld_byte_s = 8'h00;
    ld_half_s = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_lane)
      2'd0:    ld_byte_s = ld_rdata[7:0];
      2'd1:    ld_byte_s = ld_rdata[15:8];
      2'd2:    ld_byte_s = ld_rdata[23:16];
      2'd3:    ld_byte_s = ld_rdata[31:24];
      default: ld_byte_s = 8'h00;
    endcase
    case (ld_code)
      MC_BYTE_S: ld_result = {{24{ld_byte_s[7]}}, ld_byte_s};
      MC_BYTE_U: ld_result = {24'h00_0000, ld_byte_s};
      MC_HALF_S: ld_result = {{16{ld_half_s[15]}}, ld_half_s};
      MC_WORD:   ld_result = ld_rdata;
      default:   ld_result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one request at a time from the pipeline, checks
// alignment, drives a single-outstanding data-memory handshake and returns
// the extended load result with a one-cycle done pulse.
// Optional macro LSU_TIMEOUT_EN: aborts a request that waits TIMEOUT_CYCLES
// cycles in REQ without dm_ack and reports it as a fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  mem_code,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  lsu_state_e  state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [2:0]  code_q, code_d;
  logic [1:0]  lane_q, lane_d;

  logic [3:0]  st_be_s;
  logic [31:0] st_wdata_s;
  logic [31:0] ld_result_s;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  lsu_align u_align (
    .st_code          (mem_code),
    .st_lane          (addr[1:0]),
    .st_wdata         (wdata),
    .st_be            (st_be_s),
    .st_wdata_steered (st_wdata_s),
    .ld_code          (code_q),
    .ld_lane          (lane_q),
    .ld_rdata         (dm_rdata),
    .ld_result        (ld_result_s)
  );

  // Next-state and next-output logic for the request FSM
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    fault_d    = 1'b0;
    rdata_d    = rdata_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_be_d    = dm_be_q;
    dm_wdata_d = dm_wdata_q;
    code_d     = code_q;
    lane_d     = lane_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (access_legal(mem_code, addr[1:0])) begin
            state_d    = REQ;
            dm_we_d    = is_store;
            dm_addr_d  = {addr[31:2], 2'b00};
            dm_be_d    = st_be_s;
            dm_wdata_d = st_wdata_s;
            code_d     = mem_code;
            lane_d     = addr[1:0];
`ifdef LSU_TIMEOUT_EN
            cnt_d      = '0;
`endif
          end else begin
            done_d  = 1'b1;
            fault_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (dm_ack) begin
          state_d = RESP;
          done_d  = 1'b1;
          if (!dm_we_q) begin
            rdata_d = ld_result_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
`ifdef LSU_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = RESP;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
`else
          state_d = REQ;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d   = (state_d != IDLE);
    dm_req_d = (state_d == REQ);
  end

  // State and registered outputs; reset clears everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= 32'h0000_0000;
      dm_be_q    <= 4'b0000;
      dm_wdata_q <= 32'h0000_0000;
      code_q     <= 3'b000;
      lane_q     <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      rdata_q    <= rdata_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_be_q    <= dm_be_d;
      dm_wdata_q <= dm_wdata_d;
      code_q     <= code_d;
      lane_q     <= lane_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign fault    = fault_q;
  assign rdata    = rdata_q;
  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_be    = dm_be_q;
  assign dm_wdata = dm_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. Expected completions are queued
// when a request is issued and popped when done is observed.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  mem_code;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_rd;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .is_store (is_store),
    .mem_code (mem_code),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .fault    (fault),
    .rdata    (rdata),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_be    (dm_be),
    .dm_wdata (dm_wdata),
    .dm_ack   (dm_ack),
    .dm_rdata (dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and service it; illegal requests are recognised by exp_lat == 1
  task automatic do_access(input string name, input logic st, input logic [2:0] code,
                           input logic [31:0] a, input logic [31:0] wd, input int waits,
                           input logic [31:0] mem, input logic poke,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rd, input logic exp_flt, input int exp_lat);
    exp_t e;
    int   lat;
    int   rq;
    bit   seen_done;
    bit   req_seen;
    e.fault = exp_flt;
    e.rdata = exp_rd;
    e.lat   = exp_lat;
    sb_q.push_back(e);
    start = 1'b1; is_store = st; mem_code = code; addr = a; wdata = wd;
    step();
    start = poke; is_store = ~st; mem_code = 3'b001; addr = ~a; wdata = ~wd;
    lat = 1; rq = 0; seen_done = 1'b0; req_seen = 1'b0;
    while (!seen_done && lat < 80) begin
      if (dm_req) begin
        req_seen = 1'b1;
        checks++;
        if (dm_addr !== {a[31:2], 2'b00} || dm_be !== exp_be || dm_wdata !== exp_wd ||
            dm_we !== st || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s req: addr=%h be=%b wd=%h we=%b busy=%b want addr=%h be=%b wd=%h we=%b busy=1",
                   name, dm_addr, dm_be, dm_wdata, dm_we, busy, {a[31:2], 2'b00}, exp_be, exp_wd, st);
        end
        dm_ack   = (rq == waits);
        dm_rdata = (rq == waits) ? mem : 32'h5A5A_A5A5;
        rq++;
      end else begin
        dm_ack = 1'b0;
      end
      if (done) begin
        seen_done = 1'b1;
        start = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (fault !== e.fault || rdata !== e.rdata || lat != e.lat) begin
          errors++;
          $display("FAIL %s done: fault=%b rdata=%h lat=%0d want fault=%b rdata=%h lat=%0d",
                   name, fault, rdata, lat, e.fault, e.rdata, e.lat);
        end
      end else begin
        step();
        lat++;
      end
    end
    start = 1'b0;
    dm_ack = 1'b0;
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL %s no_done: waited %0d cycles, want done at %0d", name, lat, exp_lat);
    end
    checks++;
    if (req_seen !== (exp_lat > 1)) begin
      errors++;
      $display("FAIL %s req_seen: got %b want %b", name, req_seen, (exp_lat > 1));
    end
    step();
    checks++;
    if (done !== 1'b0 || dm_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after: done=%b req=%b busy=%b want 0 0 0", name, done, dm_req, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy, done, fault, dm_req, dm_we} !== 5'b00000 || dm_be !== 4'b0000 ||
        dm_addr !== 32'h0 || dm_wdata !== 32'h0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_vals: bdfrw=%b be=%b addr=%h wd=%h rd=%h want all zero",
               {busy, done, fault, dm_req, dm_we}, dm_be, dm_addr, dm_wdata, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 32'h0;
    step();
    dm_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || dm_req !== 1'b0) begin
        errors++;
        $display("FAIL idle_ack: busy=%b done=%b req=%b want 0 0 0", busy, done, dm_req);
      end
    end
    dm_ack = 1'b0;
  endtask

  task automatic test_store();
    do_access("word_store", 1'b1, 3'b011, 32'h0000_0104, 32'hDEAD_BEEF, 0, 32'h0, 1'b0,
              4'b1111, 32'hDEAD_BEEF, last_rd, 1'b0, 2);
    do_access("half_store", 1'b1, 3'b010, 32'h0000_0106, 32'h1234_ABCD, 1, 32'h0, 1'b0,
              4'b1100, 32'hABCD_ABCD, last_rd, 1'b0, 3);
    do_access("byte_store", 1'b1, 3'b001, 32'h0000_0101, 32'h0000_00A5, 0, 32'h0, 1'b0,
              4'b0010, 32'hA5A5_A5A5, last_rd, 1'b0, 2);
  endtask

  task automatic test_load();
    do_access("byte_s_load", 1'b0, 3'b001, 32'h0000_0203, 32'h0, 3, 32'h80FF_FFFF, 1'b0,
              4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0, 5);
    do_access("byte_u_load", 1'b0, 3'b101, 32'h0000_0203, 32'h0, 0, 32'h8000_0000, 1'b0,
              4'b1000, 32'h0, 32'h0000_0080, 1'b0, 2);
    do_access("half_load", 1'b0, 3'b010, 32'h0000_0202, 32'h0, 0, 32'h8001_0000, 1'b0,
              4'b1100, 32'h0, 32'hFFFF_8001, 1'b0, 2);
    do_access("word_load", 1'b0, 3'b011, 32'h0000_0300, 32'h0, 1, 32'h1234_5678, 1'b0,
              4'b1111, 32'h0, 32'h1234_5678, 1'b0, 3);
    last_rd = 32'h1234_5678;
  endtask

  task automatic test_misaligned();
    do_access("mis_word", 1'b0, 3'b011, 32'h0000_0102, 32'h0, 0, 32'hFFFF_FFFF, 1'b0,
              4'b0000, 32'h0, last_rd, 1'b1, 1);
    do_access("mis_half", 1'b1, 3'b010, 32'h0000_0201, 32'h1111_2222, 0, 32'h0, 1'b0,
              4'b0000, 32'h0, last_rd, 1'b1, 1);
    do_access("bad_code0", 1'b0, 3'b000, 32'h0000_0200, 32'h0, 0, 32'h0, 1'b0,
              4'b0000, 32'h0, last_rd, 1'b1, 1);
    do_access("bad_code7", 1'b0, 3'b111, 32'h0000_0200, 32'h0, 0, 32'h0, 1'b0,
              4'b0000, 32'h0, last_rd, 1'b1, 1);
  endtask

  task automatic test_busy();
    // start held high with scrambled inputs throughout the access
    do_access("busy_ignore", 1'b0, 3'b011, 32'h0000_0400, 32'h0, 2, 32'hCAFE_F00D, 1'b1,
              4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0, 4);
    last_rd = 32'hCAFE_F00D;
  endtask

  task automatic test_wait_or_timeout();
`ifdef LSU_TIMEOUT_EN
    int lat;
    int reqs;
    bit seen;
    start = 1'b1; is_store = 1'b0; mem_code = 3'b011; addr = 32'h0000_0600;
    step();
    start = 1'b0;
    lat = 1; reqs = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      if (dm_req) reqs++;
      if (done) begin
        seen = 1'b1;
      end else begin
        step();
        lat++;
      end
    end
    checks++;
    if (!seen || fault !== 1'b1 || reqs != 4 || lat != 5 || rdata !== last_rd) begin
      errors++;
      $display("FAIL timeout: seen=%b fault=%b reqs=%0d lat=%0d rd=%h want 1 1 4 5 %h",
               seen, fault, reqs, lat, rdata, last_rd);
    end
    dm_ack = 1'b1; dm_rdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL late_ack: done=%b busy=%b want 0 0", done, busy);
      end
    end
    dm_ack = 1'b0;
`else
    do_access("long_wait", 1'b0, 3'b101, 32'h0000_0601, 32'h0, 20, 32'h0000_C300, 1'b0,
              4'b0010, 32'h0, 32'h0000_00C3, 1'b0, 22);
    last_rd = 32'h0000_00C3;
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    start = 1'b1; is_store = 1'b1; mem_code = 3'b011; addr = 32'h0000_0700; wdata = 32'h7777_7777;
    step();
    start = 1'b0;
    step();
    checks++;
    if (dm_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: req=%b want 1", dm_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dm_req !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: req=%b busy=%b rd=%h want 0 0 0", dm_req, busy, rdata);
    end
    last_rd = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    dm_ack = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) n++;
    end
    dm_ack = 1'b0;
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL mid_no_done: %0d cycles with done/busy, want 0", n);
    end
  endtask

  initial begin
    start = 1'b0; is_store = 1'b0; mem_code = 3'b000; addr = 32'h0; wdata = 32'h0;
    dm_ack = 1'b0; dm_rdata = 32'h0; rst_n = 1'b0; last_rd = 32'h0;
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_busy();
    test_wait_or_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
